// File: rtl/req_arbiter8.sv
// req_arbiter8: grants one of 8 requesters, holds while requested, forced release after MAX_HOLD cycles.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 7 highest).
module req_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned N_REQ = 8;
   localparam int unsigned ID_W  = 3;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]   win_id;
`ifdef ROUND_ROBIN_EN
   logic [ID_W-1:0]   last_id_q, last_id_d;
   logic [ID_W-1:0]   cand;
`endif

   // Winner selection; later loop iterations have higher priority
   always_comb begin
      win_id = '0;
`ifdef ROUND_ROBIN_EN
      cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = last_id_q - ID_W'(k);
         if (req[cand]) win_id = cand;
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) win_id = ID_W'(i);
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
`ifdef ROUND_ROBIN_EN
      last_id_d   = last_id_q;
`endif
      case (state_q)
         IDLE: begin
            if (req != '0) begin
               gnt_d       = N_REQ'(1) << win_id;
               gnt_id_d    = win_id;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
`ifdef ROUND_ROBIN_EN
               last_id_d   = win_id;
`endif
               state_d     = GRANT;
            end else begin
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + CNT_W'(1);
            if (!req[gnt_id_q]) begin
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               state_d     = IDLE;
            end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
`ifdef ROUND_ROBIN_EN
         last_id_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef ROUND_ROBIN_EN
         last_id_q   <= last_id_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

- Arbitrates one shared resource among 8 requesters.
- Grants exactly one requester at a time and holds the grant while that requester keeps its request asserted.
- Forces release after a configurable maximum hold time.
- Sits in front of the shared datapath. Requester index priority matches the 8-to-3 priority encoding: bit 7 is highest.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum cycles one grant may be held; 0 disables the timeout. Legal range 0–255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req  input  8  request vector; req[i] high = requester i wants the resource
- gnt  output  8  one-hot grant, registered; all zero when no grant
- gnt_id  output  3  binary index of the granted requester, valid when gnt_valid=1
- gnt_valid  output  1  high while any grant is active (equals |gnt)
- timeout  output  1  one-cycle pulse when a grant is forcibly released

## Operation
- Single clock domain: clk. Reset is asynchronous and active-high on rst.
- FSM states:
  - IDLE: on each edge, if req != 0, select a winner, load gnt/gnt_id, set gnt_valid, clear hold_cnt, go to GRANT. If req == 0, stay in IDLE with outputs zero.
  - GRANT: each edge, hold_cnt increments (saturating, 8-bit).
    - If req[gnt_id]=0: clear gnt, gnt_id, gnt_valid; go to IDLE.
    - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: clear grant, pulse timeout for one cycle, go to IDLE.
    - Else: hold the grant.
- Release from GRANT always passes through IDLE. This forces one bubble cycle of gnt=0 between any two grants, including a re-grant to the same requester.
- Winner selection, fixed priority (macro absent): highest set index of req wins.
- Other requests never pre-empt an active grant. Changes in req bits other than req[gnt_id] are ignored during GRANT.
- gnt_id is driven to 0 whenever gnt_valid=0.
- Reset values: state=IDLE, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, hold_cnt=0, last_id=3'd0.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock. The first grant after reset deassertion is judged on the first rising edge with rst low.

## Timing
- Request-to-grant latency: 1 cycle. req sampled at edge N in IDLE gives gnt valid after edge N.
- Release latency: 1 cycle. req[gnt_id] sampled low at edge N gives gnt=0 after edge N. A new grant is possible after edge N+1.
- With continuous request and MAX_HOLD=M, gnt stays high for exactly M cycles. timeout is high in the cycle after the last granted cycle, concurrent with the bubble.
- When MAX_HOLD=0, timeout is never asserted.
- Requesters must hold req until granted. A request that drops before being sampled in IDLE is lost, with no error.

## Configuration
- Macro: ROUND_ROBIN_EN.
- Absent: fixed priority; requester 7 highest, requester 0 lowest. Under sustained load a high-priority requester can starve lower ones; the timeout only inserts bubbles.
- Defined: rotating priority.
  - last_id records the index of each grant.
  - Search order is descending from last_id-1, wrapping mod 8, ending at last_id itself, so the previous holder gets lowest priority.
  - Because last_id resets to 0, the first search after reset starts at 7 and matches fixed priority.
  - A requester that times out moves to lowest priority.

## Test plan
- Basic grant: req=8'b0010_0100 in IDLE -> one cycle later gnt=8'b0010_0000, gnt_id=5, gnt_valid=1. Drop req[5] -> gnt=0 next cycle, then gnt=8'b0000_0100, gnt_id=2 one cycle after.
- No pre-emption: while requester 2 is granted, raise req[7] -> gnt stays 8'b0000_0100 until req[2] drops, then bubble, then gnt_id=7.
- Timeout, MAX_HOLD=4: hold req=8'b0000_0001 -> gnt high exactly 4 cycles, timeout pulse one cycle with gnt=0, re-grant to 0 on the next cycle. Repeat with MAX_HOLD=0 -> grant never released, timeout stays 0.
- Round robin (ROUND_ROBIN_EN, MAX_HOLD=2): req=8'hFF held -> grant sequence 7,6,5,4,3,2,1,0,7 with one-cycle bubbles. Without the macro -> grant sequence 7,7,7…
- Reset mid-grant: assert rst asynchronously while gnt=8'b1000_0000 -> gnt, gnt_id, gnt_valid, and timeout go to 0 before the next edge. After rst deasserts with req=8'h81 -> gnt_id=7 on the first edge.
- Idle stability: req=0 for 20 cycles after reset -> all outputs remain 0 and timeout never pulses.
